// File: rtl/usb_eb_reader_pkg.sv
// Shared receive-PHY symbol constants and elastic-buffer reader state encoding.
package usb_eb_reader_pkg;

    localparam int SYM_W = 9;

    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_5 = 8'hBC;

    localparam logic [SYM_W-1:0] SKP_SYM = {1'b1, K28_1};
    localparam logic [SYM_W-1:0] COM_SYM = {1'b1, K28_5};

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_INSERT = 2'd2
    } eb_state_t;

    function automatic logic is_skp(input logic [SYM_W-1:0] sym);
        return sym == SKP_SYM;
    endfunction

endpackage

// File: rtl/usb_eb_reader.sv
// Elastic-buffer read side: pops FIFO symbols and pads SKP pairs when the FIFO runs low.
// Latency: popped symbol appears on sym_* one rclk after the pop.
// Backpressure: none downstream; pops stall only while filling or inserting.
module usb_eb_reader
    import usb_eb_reader_pkg::*;
#(
    parameter int ASIZE    = 8,
    parameter int LO_MARK  = 96,
    parameter int HI_MARK  = 160,
    parameter int MID_MARK = 128,
    parameter int MAX_INS  = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [8:0]       fifo_rdata,
    input  logic             fifo_rempty,
    input  logic [ASIZE:0]   fifo_level,
    output logic             fifo_rinc,
    output logic [7:0]       sym_data,
    output logic             sym_k,
    output logic             sym_valid,
    output logic             skp_added,
    output logic             underflow,
    output logic             hi_warn,
    output logic [15:0]      ins_total
);

    localparam logic [ASIZE:0] LO_LVL  = (ASIZE+1)'(LO_MARK);
    localparam logic [ASIZE:0] MID_LVL = (ASIZE+1)'(MID_MARK);
    localparam logic [ASIZE:0] HI_LVL  = (ASIZE+1)'(HI_MARK);
    localparam logic [1:0]     MAX_CNT = 2'(MAX_INS);

    if (!(LO_MARK < MID_MARK && MID_MARK < HI_MARK && HI_MARK < (1 << ASIZE))) begin : g_mark_check
        $error("usb_eb_reader: marks must satisfy LO_MARK < MID_MARK < HI_MARK < depth");
    end

    eb_state_t  state;
    logic       skp_run;
    logic [1:0] ins_cnt;
    logic       phase;

    logic head_skp;
    logic ins_trig;

    assign fifo_rinc = (state == ST_RUN) && !fifo_rempty;
    assign head_skp  = is_skp(fifo_rdata);

    // Only pad right after a completed received pair so ordered sets keep even SKP counts.
    assign ins_trig = head_skp && skp_run && (fifo_level < LO_LVL) && (ins_cnt < MAX_CNT);

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= ST_FILL;
            skp_run   <= 1'b0;
            ins_cnt   <= 2'd0;
            phase     <= 1'b0;
            sym_data  <= 8'h00;
            sym_k     <= 1'b0;
            sym_valid <= 1'b0;
            skp_added <= 1'b0;
            underflow <= 1'b0;
            hi_warn   <= 1'b0;
            ins_total <= 16'h0000;
        end else begin
            skp_added <= 1'b0;
            underflow <= 1'b0;
            hi_warn   <= (fifo_level >= HI_LVL);

            case (state)
                ST_FILL: begin
                    sym_valid <= 1'b0;
                    if (fifo_level >= MID_LVL) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!fifo_rempty) begin
                        sym_valid <= 1'b1;
                        sym_k     <= fifo_rdata[8];
                        sym_data  <= fifo_rdata[7:0];
                        if (head_skp) begin
                            skp_run <= ~skp_run;
                        end else begin
                            skp_run <= 1'b0;
                            ins_cnt <= 2'd0;
                        end
                        if (ins_trig) begin
                            state   <= ST_INSERT;
                            ins_cnt <= ins_cnt + 2'd1;
                            phase   <= 1'b0;
                        end
                    end else begin
                        sym_valid <= 1'b0;
                        underflow <= 1'b1;
                        skp_run   <= 1'b0;
                        ins_cnt   <= 2'd0;
                        state     <= ST_FILL;
                    end
                end

                ST_INSERT: begin
                    sym_valid <= 1'b1;
                    sym_k     <= 1'b1;
                    sym_data  <= K28_1;
                    phase     <= ~phase;
                    if (!phase) begin
                        skp_added <= 1'b1;
                        if (ins_total != 16'hFFFF) begin
                            ins_total <= ins_total + 16'd1;
                        end
                    end else begin
                        state <= ST_RUN;
                    end
                end

                default: begin
                    state     <= ST_FILL;
                    sym_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
